// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory boot loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCsum,
    StDone
  } state_t;

  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned WORD_ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted little-endian bytes into a 32-bit word and pulses word_ready
// for one cycle after the 4th byte of each word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_ready,
  output logic        last_byte
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic        ready_q, ready_d;

  assign last_byte  = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = word_q;
  assign word_ready = ready_q;

  always_comb begin
    cnt_d   = cnt_q;
    word_d  = word_q;
    ready_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (byte_valid) begin
      // Shift right so the first byte of the group ends up in [7:0].
      word_d  = {in_byte, word_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      ready_d = last_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into instruction memory and holds the core in reset
// until loaded. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             done,
  output logic             err,
  output logic             cpu_rst
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [CNT_W-1:0] count_clamped;
  logic [31:0]      waddr_q, waddr_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             accept, pack_accept, pack_clear, last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
  logic             err_q, err_d;
`endif

  assign count_clamped = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
  assign in_ready      = (state_q == StLoad) || (state_q == StCsum);
  assign accept        = in_valid && in_ready;
  assign pack_accept   = accept && (state_q == StLoad);
  assign done          = (state_q == StDone);
  assign waddr         = waddr_q;
  assign cpu_rst       = cpu_rst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_valid (pack_accept),
    .in_byte    (in_byte),
    .word       (wdata),
    .word_ready (we),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    waddr_d    = waddr_q;
    cpu_rst_d  = 1'b1;
    pack_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          cpu_rst_d = err_q;
`else
          cpu_rst_d = 1'b0;
`endif
        end
        if (start) begin
          count_d    = count_clamped;
          index_d    = '0;
          pack_clear = 1'b1;
          cpu_rst_d  = 1'b1;
          state_d    = (count_clamped == '0) ? StDone : StLoad;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (pack_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_byte;
`endif
          if (last_byte) begin
            // Address is captured now so it lines up with the registered write strobe.
            waddr_d = 32'(index_q) << WORD_ADDR_SHIFT;
            index_d = index_q + CNT_W'(1);
            if (index_q == count_q - CNT_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          err_d   = (in_byte != csum_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      index_q   <= '0;
      waddr_q   <= '0;
      cpu_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      index_q   <= index_d;
      waddr_q   <= waddr_d;
      cpu_rst_q <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with random bytes and
// gaps, checked against a byte-stream reference model, plus reset/checksum cases.
module tb_imem_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             in_ready, we, done, err, cpu_rst;
  logic [31:0]      waddr, wdata;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .done       (done),
    .err        (err),
    .cpu_rst    (cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned wc;
    int unsigned gap;
    int unsigned exp_writes;
    logic [31:0] exp_last_addr;
  } vec_t;

  int unsigned n_tests, n_fail;
  logic [7:0]  stream [0:127];
  logic [7:0]  prog [0:11];
  logic [31:0] got_addr[$], got_data[$];
  logic        order_ok, last_we_done, first_done;
  int unsigned sample_no;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called once per cycle, just after the falling edge; accepted = bytes taken so far.
  task automatic sample(input int unsigned accepted);
    if (we) begin
      if (accepted != 4 * (got_addr.size() + 1)) order_ok = 1'b0;
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
      last_we_done = done;
    end
    if (sample_no == 0) first_done = done;
    sample_no++;
  endtask

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    order_ok     = 1'b1;
    last_we_done = 1'b0;
    first_done   = 1'b0;
    sample_no    = 0;
  endtask

  // Must be entered right at a falling edge.
  task automatic run_load(input int unsigned wc, input int unsigned gap, input bit bad_csum,
                          input string tag);
    int unsigned eff, nbytes, i, budget;
    bit          fire;
    logic        exp_err;
    eff    = (wc > DEPTH) ? DEPTH : wc;
    nbytes = 4 * eff;
    i      = 0;
    budget = 3000;
    exp_err = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (eff > 0) begin
      logic [7:0] x;
      x = 8'h00;
      for (int b = 0; b < int'(nbytes); b++) x ^= stream[b];
      stream[nbytes] = bad_csum ? (x ^ 8'h03) : x;
      nbytes++;
      exp_err = bad_csum;
    end
`else
    if (bad_csum) exp_err = 1'b0;
`endif
    clear_obs();
    start      = 1'b1;
    word_count = CNT_W'(wc);
    @(negedge clk);
    start = 1'b0;
    while (i < nbytes && budget > 0) begin
      in_valid = ($urandom_range(99) >= gap);
      in_byte  = stream[i];
      #1;
      fire = in_valid && in_ready;
      sample(i);
      @(negedge clk);
      if (fire) i++;
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) check({tag, " bytes_accepted_before_timeout"}, i, nbytes);
    repeat (3) begin
      #1 sample(i);
      @(negedge clk);
    end
    #1;
    check({tag, " write_count"}, 32'(got_addr.size()), eff);
    for (int k = 0; k < got_addr.size() && k < int'(eff); k++) begin
      check({tag, " waddr"}, got_addr[k], 32'(4 * k));
      check({tag, " wdata"}, got_data[k],
            {stream[4*k+3], stream[4*k+2], stream[4*k+1], stream[4*k]});
    end
    check({tag, " write_after_4th_byte"}, order_ok, 1'b1);
    check({tag, " done"}, done, 1'b1);
    check({tag, " err"}, err, exp_err);
    check({tag, " cpu_rst"}, cpu_rst, exp_err);
    check({tag, " in_ready_done"}, in_ready, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (eff > 0) check({tag, " done_with_last_we"}, last_we_done, 1'b1);
`endif
    if (eff == 0) check({tag, " done_one_cycle_after_start"}, first_done, 1'b1);
    @(negedge clk);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{wc: 0,  gap: 0,  exp_writes: 0,  exp_last_addr: 32'd0};
    vecs[1] = '{wc: 1,  gap: 30, exp_writes: 1,  exp_last_addr: 32'd0};
    vecs[2] = '{wc: 5,  gap: 20, exp_writes: 5,  exp_last_addr: 32'd16};
    vecs[3] = '{wc: 16, gap: 10, exp_writes: 16, exp_last_addr: 32'd60};
    vecs[4] = '{wc: 20, gap: 0,  exp_writes: 16, exp_last_addr: 32'd60};
    prog = '{8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h30, 8'h00,
             8'hB3, 8'h83, 8'h62, 8'h00};
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; word_count = '0; in_valid = 1'b0; in_byte = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    check("reset in_ready", in_ready, 1'b0);
    check("reset we", we, 1'b0);
    check("reset waddr", waddr, 32'h0);
    check("reset wdata", wdata, 32'h0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset cpu_rst", cpu_rst, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle in_ready", in_ready, 1'b0);
    check("idle cpu_rst", cpu_rst, 1'b1);

    for (int b = 0; b < 12; b++) stream[b] = prog[b];
    run_load(3, 0, 1'b0, "prog");
    check("prog word0", got_data[0], 32'h00500293);
    check("prog word1", got_data[1], 32'h00300313);
    check("prog word2", got_data[2], 32'h006283B3);
    run_load(3, 60, 1'b0, "throttled");

    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 128; b++) stream[b] = 8'($urandom);
      run_load(vecs[v].wc, vecs[v].gap, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d writes", v), 32'(got_addr.size()), vecs[v].exp_writes);
      if (got_addr.size() > 0)
        check($sformatf("vec%0d last_addr", v), got_addr[$], vecs[v].exp_last_addr);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int b = 0; b < 4; b++) stream[b] = prog[b];
    run_load(1, 0, 1'b0, "csum_ok");
    run_load(1, 0, 1'b1, "csum_bad");
    run_load(1, 0, 1'b0, "csum_recover");
`endif

    // Reset after six bytes of a three-word load.
    for (int b = 0; b < 12; b++) stream[b] = prog[b];
    clear_obs();
    start = 1'b1;
    word_count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      in_valid = 1'b1;
      in_byte  = stream[b];
      #1 sample(b);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1 sample(6);
    rst = 1'b1;
    #1;
    check("midrst writes", 32'(got_addr.size()), 32'd1);
    check("midrst addr", got_addr[0], 32'h0);
    check("midrst in_ready", in_ready, 1'b0);
    check("midrst we", we, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst cpu_rst", cpu_rst, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst idle in_ready", in_ready, 1'b0);
    run_load(3, 25, 1'b0, "reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
